// File: rtl/instr_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_loader_if
//  Purpose  : Byte-stream input channel plus instruction-memory write bus
//             seen by the program loader.
//  Revision : 1.0 - initial release
// ============================================================================
interface instr_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [31:0] wr_data;

    // Byte source and instruction memory side
    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    // Loader side
    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
//  Module   : instr_loader
//  Purpose  : Fills instruction memory from a byte stream: 16-bit LE word
//             count, then LE instruction bytes packed into 32-bit words
//             written at consecutive word-aligned addresses from 0.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_loader #(
    parameter int unsigned MEM_SIZE = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    instr_loader_if.slave     bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    // Largest legal header count, held at 17 bits so the compare never truncates
    localparam logic [16:0] c_MAX_WORDS = 17'(MEM_SIZE / 4);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_DATA  = 3'd3,
        S_WLAST = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_count;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_word_buf;     // bytes 0..2 of the word being assembled
    logic        r_wr_en;
    logic [63:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic [15:0] r_words_loaded; // doubles as the index of the next word
    logic        r_busy;
    logic        r_done;
    logic        r_error;

    logic        w_in_ready;
    logic        w_xfer;
    logic        w_start_ok;
    logic [15:0] w_count_full;
    logic        w_too_big;
    logic        w_last_word;

    assign w_in_ready   = (r_state == S_HDR0) || (r_state == S_HDR1) || (r_state == S_DATA);
    assign w_xfer       = bus.in_valid && w_in_ready;
    assign w_start_ok   = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_count_full = {bus.in_data, r_count[7:0]};
    assign w_too_big    = {1'b0, w_count_full} > c_MAX_WORDS;
    assign w_last_word  = (r_words_loaded == (r_count - 16'd1));

    // Next-state decode for the session sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_HDR0;
            S_HDR0:  if (w_xfer) w_state_nxt = S_HDR1;
            S_HDR1: begin
                if (w_xfer) begin
                    if (w_count_full == 16'd0) w_state_nxt = S_DONE;
                    else if (w_too_big)        w_state_nxt = S_ERR;
                    else                       w_state_nxt = S_DATA;
                end
            end
            S_DATA:  if (w_xfer && (r_byte_idx == 2'd3) && w_last_word) w_state_nxt = S_WLAST;
            S_WLAST: w_state_nxt = S_DONE;
            S_DONE:  if (start) w_state_nxt = S_HDR0;
            S_ERR:   if (start) w_state_nxt = S_HDR0;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register, with busy registered from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_HDR0) || (w_state_nxt == S_HDR1) ||
                       (w_state_nxt == S_DATA) || (w_state_nxt == S_WLAST);
        end
    end

    // Header capture, byte packing, write strobe and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count        <= 16'd0;
            r_byte_idx     <= 2'd0;
            r_word_buf     <= 24'd0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= 64'd0;
            r_wr_data      <= 32'd0;
            r_words_loaded <= 16'd0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_start_ok) begin
                r_count        <= 16'd0;
                r_byte_idx     <= 2'd0;
                r_word_buf     <= 24'd0;
                r_words_loaded <= 16'd0;
                r_done         <= 1'b0;
                r_error        <= 1'b0;
            end
            case (r_state)
                S_HDR0: if (w_xfer) r_count[7:0] <= bus.in_data;
                S_HDR1: begin
                    if (w_xfer) begin
                        r_count[15:8] <= bus.in_data;
                        if (w_count_full == 16'd0) r_done  <= 1'b1;
                        else if (w_too_big)        r_error <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        case (r_byte_idx)
                            2'd0: r_word_buf[7:0]   <= bus.in_data;
                            2'd1: r_word_buf[15:8]  <= bus.in_data;
                            2'd2: r_word_buf[23:16] <= bus.in_data;
                            default: begin
                                r_wr_en        <= 1'b1;
                                r_wr_data      <= {bus.in_data, r_word_buf};
                                r_wr_addr      <= {46'd0, r_words_loaded, 2'b00};
                                r_words_loaded <= r_words_loaded + 16'd1;
                            end
                        endcase
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                end
                S_WLAST: r_done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words_loaded;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_loader
//  Purpose  : Self-checking bench for instr_loader (MEM_SIZE = 1024).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [15:0] words_loaded;

    instr_loader_if bus ();

    instr_loader #(.MEM_SIZE(1024)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .bus          (bus.slave),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_writes = 0;
    logic [95:0] exp_q[$];   // {addr, data}

    typedef struct {
        logic [15:0] count;
        logic [31:0] seed;
        bit          gaps;
        logic        exp_done;
        logic        exp_err;
        logic [15:0] exp_words;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected word
    always @(negedge clk) begin
        if (reset_n && bus.wr_en) begin
            logic [95:0] e;
            n_writes++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", bus.wr_addr, bus.wr_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.wr_addr !== e[95:32] || bus.wr_data !== e[31:0]) begin
                    n_fail++;
                    $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                             bus.wr_addr, bus.wr_data, e[95:32], e[31:0]);
                end
            end
        end
    end

    // All tasks enter and leave just after a falling edge
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t = 0;
        if (gaps) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 50) begin
            n_fail++;
            $display("FAIL handshake_timeout: got in_ready 0 expected 1");
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] idx, input logic [31:0] w, input bit gaps);
        exp_q.push_back({{46'd0, idx, 2'b00}, w});
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
    endtask

    task automatic wait_end();
        int t = 0;
        while (!(done || error) && t < 40) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 40) begin
            n_fail++;
            $display("FAIL end_timeout: got done %0b error %0b expected one set", done, error);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_wr_en"},    64'(bus.wr_en),    64'd0);
        check({tag, "_wr_addr"},  bus.wr_addr,       64'd0);
        check({tag, "_wr_data"},  64'(bus.wr_data),  64'd0);
        check({tag, "_busy"},     64'(busy),         64'd0);
        check({tag, "_done"},     64'(done),         64'd0);
        check({tag, "_error"},    64'(error),        64'd0);
        check({tag, "_words"},    64'(words_loaded), 64'd0);
    endtask

    vec_t vecs[7];

    initial begin
        logic [7:0] two_word[10];
        int w0;

        vecs[0] = '{16'd0,     32'h0,        1'b0, 1'b1, 1'b0, 16'd0};
        vecs[1] = '{16'd1,     32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 16'd1};
        vecs[2] = '{16'd3,     32'h01020304, 1'b1, 1'b1, 1'b0, 16'd3};
        vecs[3] = '{16'd257,   32'h0,        1'b0, 1'b0, 1'b1, 16'd0};
        vecs[4] = '{16'd256,   32'h13579BDF, 1'b0, 1'b1, 1'b0, 16'd256};
        vecs[5] = '{16'hFFFF,  32'h0,        1'b0, 1'b0, 1'b1, 16'd0};
        vecs[6] = '{16'd300,   32'h0,        1'b1, 1'b0, 1'b1, 16'd0};

        two_word = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Power-up reset
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_in_ready", 64'(bus.in_ready), 64'd0);

        // Two-word load, continuous valid, exact edge timing
        exp_q.push_back({64'h0, 32'h12345678});
        exp_q.push_back({64'h4, 32'hDEADBEEF});
        w0 = n_writes;
        start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = two_word[0];
        @(negedge clk);                 // edge 0 samples start
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = two_word[i];
            check("tw_in_ready", 64'(bus.in_ready), 64'd1);
            @(negedge clk);             // byte i taken at edge i+1
        end
        bus.in_valid = 1'b0;
        check("tw_done_e10", 64'(done), 64'd0);
        check("tw_busy_e10", 64'(busy), 64'd1);
        check("tw_wren_e10", 64'(bus.wr_en), 64'd1);
        @(negedge clk);
        check("tw_done_e11",  64'(done), 64'd1);
        check("tw_busy_e11",  64'(busy), 64'd0);
        check("tw_words",     64'(words_loaded), 64'd2);
        check("tw_nwrites",   64'(n_writes - w0), 64'd2);

        // Zero count: done at the second header edge, next byte not consumed
        w0 = n_writes;
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        bus.in_data = 8'hAA;            // valid stays high
        check("zero_done",     64'(done), 64'd1);
        check("zero_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (3) @(negedge clk);
        check("zero_in_ready_hold", 64'(bus.in_ready), 64'd0);
        check("zero_nwrites", 64'(n_writes - w0), 64'd0);
        bus.in_valid = 1'b0;

        // Table of sessions
        for (int v = 0; v < 7; v++) begin
            w0 = n_writes;
            do_start();
            check("vec_busy_start", 64'(busy), 64'd1);
            send_byte(vecs[v].count[7:0], vecs[v].gaps);
            send_byte(vecs[v].count[15:8], vecs[v].gaps);
            if (!vecs[v].exp_err)
                for (int i = 0; i < int'(vecs[v].count); i++)
                    send_word(16'(i), vecs[v].seed + 32'(i) * 32'h9E3779B9, vecs[v].gaps);
            bus.in_valid = 1'b0;
            wait_end();
            @(negedge clk);
            check("vec_done",     64'(done),  64'(vecs[v].exp_done));
            check("vec_error",    64'(error), 64'(vecs[v].exp_err));
            check("vec_words",    64'(words_loaded), 64'(vecs[v].exp_words));
            check("vec_nwrites",  64'(n_writes - w0), 64'(vecs[v].exp_words));
            check("vec_busy",     64'(busy), 64'd0);
            check("vec_in_ready", 64'(bus.in_ready), 64'd0);
            if (vecs[v].exp_words != 16'd0)
                check("vec_last_addr", bus.wr_addr, 64'({vecs[v].exp_words - 16'd1, 2'b00}));
        end

        // Gaps, start ignored during DATA, restart from DONE
        w0 = n_writes;
        do_start();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        exp_q.push_back({64'h0, 32'h12345678});
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        bus.in_valid = 1'b0;
        do_start();
        check("ign_busy",     64'(busy), 64'd1);
        check("ign_in_ready", 64'(bus.in_ready), 64'd1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        send_word(16'd1, 32'hDEADBEEF, 1'b1);
        bus.in_valid = 1'b0;
        wait_end();
        check("gap_done",    64'(done), 64'd1);
        check("gap_words",   64'(words_loaded), 64'd2);
        check("gap_nwrites", 64'(n_writes - w0), 64'd2);
        do_start();
        check("rst_done_clr", 64'(done), 64'd0);
        check("rst_busy",     64'(busy), 64'd1);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_words",    64'(words_loaded), 64'd0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        bus.in_valid = 1'b0;
        check("rst_zero_done", 64'(done), 64'd1);

        // Reset mid-word, then a fresh single-word session
        do_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hF1, 1'b0);
        send_byte(8'hF2, 1'b0);
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_reset_values("mid");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_idle_in_ready", 64'(bus.in_ready), 64'd0);
        w0 = n_writes;
        do_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(16'd0, 32'h44332211, 1'b0);
        bus.in_valid = 1'b0;
        wait_end();
        check("mid_done",    64'(done), 64'd1);
        check("mid_nwrites", 64'(n_writes - w0), 64'd1);
        check("mid_q_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
